// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Encodes MIPS instructions (R-type, lw, sw, beq, addi, j) from field-level requests and
//   writes them into instruction memory sequentially from BASE_ADDR upward. It is used to
//   preload programs before the core is released.
// Ports
//   clk_i            rising-edge clock
//   reset_i          synchronous active-high reset
//   start_i          1-cycle pulse: restart at BASE_ADDR, clear done/full/err/count
//   in_valid_i       request valid
//   in_ready_o       loader can accept a request
//   in_kind_i        0=RTYPE 1=LW 2=SW 3=BEQ 4=ADDI 5=J; 6,7 illegal
//   in_rs_i .. in_target_i  instruction fields
//   in_last_i        request is the final instruction of the program
//   imem_we_o        instruction-memory write strobe
//   imem_addr_o      word address of the write
//   imem_wdata_o     encoded instruction
//   loaded_count_o   words written since reset/start
//   done_o           load finished (last word written or memory full)
//   full_o           every word from BASE_ADDR to the top has been written
//   err_o            sticky: an illegal in_kind was received
module instr_mem_loader #(
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [2:0]        in_kind_i,
   input  logic [4:0]        in_rs_i,
   input  logic [4:0]        in_rt_i,
   input  logic [4:0]        in_rd_i,
   input  logic [4:0]        in_shamt_i,
   input  logic [5:0]        in_funct_i,
   input  logic [15:0]       in_imm_i,
   input  logic [25:0]       in_target_i,
   input  logic              in_last_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic [ADDR_W:0]   loaded_count_o,
   output logic              done_o,
   output logic              full_o,
   output logic              err_o
);

   typedef enum logic [1:0] {StLoad, StWrite, StDone} state_e;

   localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] TopAddr  = '1;
   localparam logic [ADDR_W:0]   CountOne = {{ADDR_W{1'b0}}, 1'b1};

   state_e      state_q;
   logic        last_q;
   logic [31:0] enc_word;
   logic        enc_legal;

   always_comb begin
      enc_word  = 32'h0;
      enc_legal = 1'b1;
      unique case (in_kind_i)
         3'd0:    enc_word = {6'b000000, in_rs_i, in_rt_i, in_rd_i, in_shamt_i, in_funct_i};
         3'd1:    enc_word = {6'b100011, in_rs_i, in_rt_i, in_imm_i};
         3'd2:    enc_word = {6'b101011, in_rs_i, in_rt_i, in_imm_i};
         3'd3:    enc_word = {6'b000100, in_rs_i, in_rt_i, in_imm_i};
         3'd4:    enc_word = {6'b001000, in_rs_i, in_rt_i, in_imm_i};
         3'd5:    enc_word = {6'b000010, in_target_i};
         default: enc_legal = 1'b0;
      endcase
   end

   // imem_addr_o doubles as the write pointer; all outputs are registered.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q        <= StLoad;
         last_q         <= 1'b0;
         in_ready_o     <= 1'b1;
         imem_we_o      <= 1'b0;
         imem_addr_o    <= BaseAddr;
         imem_wdata_o   <= 32'h0;
         loaded_count_o <= '0;
         done_o         <= 1'b0;
         full_o         <= 1'b0;
         err_o          <= 1'b0;
      end else if (start_i) begin
         // A write strobed this cycle has already been presented; it completes on this edge.
         state_q        <= StLoad;
         in_ready_o     <= 1'b1;
         imem_we_o      <= 1'b0;
         imem_addr_o    <= BaseAddr;
         loaded_count_o <= '0;
         done_o         <= 1'b0;
         full_o         <= 1'b0;
         err_o          <= 1'b0;
      end else begin
         imem_we_o <= 1'b0;
         unique case (state_q)
            StLoad: begin
               if (in_valid_i) begin
                  if (enc_legal) begin
                     imem_wdata_o <= enc_word;
                     last_q       <= in_last_i;
                     imem_we_o    <= 1'b1;
                     in_ready_o   <= 1'b0;
                     state_q      <= StWrite;
                  end else begin
                     err_o <= 1'b1;
                     if (in_last_i) begin
                        in_ready_o <= 1'b0;
                        done_o     <= 1'b1;
                        state_q    <= StDone;
                     end
                  end
               end
            end
            StWrite: begin
               loaded_count_o <= loaded_count_o + CountOne;
               if (imem_addr_o == TopAddr) begin
                  // Pointer never wraps: hold at the top and finish as full.
                  full_o  <= 1'b1;
                  done_o  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  imem_addr_o <= imem_addr_o + 1'b1;
                  if (last_q) begin
                     done_o  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     in_ready_o <= 1'b1;
                     state_q    <= StLoad;
                  end
               end
            end
            StDone: begin
               in_ready_o <= 1'b0;
            end
            default: begin
               state_q <= StLoad;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a 64-word instance (A) and a 4-word instance (B) share fields,
// start and reset; each has its own in_valid. A queue-based model tracks expected writes.
module tb_instr_mem_loader;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, valid_a, valid_b, last;
   logic [2:0]  kind;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [25:0] target;

   logic        a_ready, a_we, a_done, a_full, a_err;
   logic [5:0]  a_addr;
   logic [31:0] a_wdata;
   logic [6:0]  a_count;
   logic        b_ready, b_we, b_done, b_full, b_err;
   logic [1:0]  b_addr;
   logic [31:0] b_wdata;
   logic [2:0]  b_count;

   instr_mem_loader #(.ADDR_W(6), .BASE_ADDR(0)) u_dut_a (
      .clk_i(clk), .reset_i(reset), .start_i(start), .in_valid_i(valid_a),
      .in_ready_o(a_ready), .in_kind_i(kind), .in_rs_i(rs), .in_rt_i(rt), .in_rd_i(rd),
      .in_shamt_i(shamt), .in_funct_i(funct), .in_imm_i(imm), .in_target_i(target),
      .in_last_i(last), .imem_we_o(a_we), .imem_addr_o(a_addr), .imem_wdata_o(a_wdata),
      .loaded_count_o(a_count), .done_o(a_done), .full_o(a_full), .err_o(a_err)
   );

   instr_mem_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_dut_b (
      .clk_i(clk), .reset_i(reset), .start_i(start), .in_valid_i(valid_b),
      .in_ready_o(b_ready), .in_kind_i(kind), .in_rs_i(rs), .in_rt_i(rt), .in_rd_i(rd),
      .in_shamt_i(shamt), .in_funct_i(funct), .in_imm_i(imm), .in_target_i(target),
      .in_last_i(last), .imem_we_o(b_we), .imem_addr_o(b_addr), .imem_wdata_o(b_wdata),
      .loaded_count_o(b_count), .done_o(b_done), .full_o(b_full), .err_o(b_err)
   );

   // Observed view of the DUT under test (sel: 0 = A, 1 = B).
   bit          sel;
   logic        o_ready, o_we, o_done, o_full, o_err;
   logic [5:0]  o_addr;
   logic [31:0] o_wdata;
   logic [6:0]  o_count;
   always_comb begin
      o_ready = sel ? b_ready : a_ready;
      o_we    = sel ? b_we    : a_we;
      o_done  = sel ? b_done  : a_done;
      o_full  = sel ? b_full  : a_full;
      o_err   = sel ? b_err   : a_err;
      o_addr  = sel ? {4'b0, b_addr} : a_addr;
      o_wdata = sel ? b_wdata : a_wdata;
      o_count = sel ? {4'b0, b_count} : a_count;
   end

   logic [37:0] wr_log[$];
   logic [37:0] exp_q[$];
   always @(posedge clk) if (o_we) wr_log.push_back({o_addr, o_wdata});

   int n_cmp, n_bad;
   int m_ptr, m_count, m_top;
   bit m_err, m_done, m_full;

   function automatic logic [31:0] encode(input logic [2:0] k, input logic [4:0] r_s, r_t, r_d,
                                          s_h, input logic [5:0] f_n, input logic [15:0] i_m,
                                          input logic [25:0] t_g);
      case (k)
         3'd0:    return {6'h00, r_s, r_t, r_d, s_h, f_n};
         3'd1:    return {6'h23, r_s, r_t, i_m};
         3'd2:    return {6'h2B, r_s, r_t, i_m};
         3'd3:    return {6'h04, r_s, r_t, i_m};
         3'd4:    return {6'h08, r_s, r_t, i_m};
         3'd5:    return {6'h02, t_g};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_restart();
      m_ptr = 0; m_count = 0; m_err = 0; m_done = 0; m_full = 0;
      m_top = sel ? 3 : 63;
      exp_q.delete();
      wr_log.delete();
   endtask

   task automatic do_reset();
      valid_a = 0; valid_b = 0; start = 0; reset = 1;
      @(negedge clk); @(negedge clk);
      reset = 0;
      model_restart();
   endtask

   task automatic do_start();
      start = 1;
      @(negedge clk);
      start = 0;
      model_restart();
   endtask

   // Called at a negedge. Returns at the negedge after the accepting edge (the WRITE cycle).
   task automatic req(input logic [2:0] k, input logic [4:0] r_s, r_t, r_d, s_h,
                      input logic [5:0] f_n, input logic [15:0] i_m, input logic [25:0] t_g,
                      input logic l);
      int waited;
      kind = k; rs = r_s; rt = r_t; rd = r_d; shamt = s_h; funct = f_n; imm = i_m;
      target = t_g; last = l;
      if (sel) valid_b = 1; else valid_a = 1;
      waited = 0;
      while (o_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (o_ready !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL req_ready_timeout: in_ready=%b after %0d cycles, required 1", o_ready,
                  waited);
         valid_a = 0; valid_b = 0;
         return;
      end
      @(posedge clk);
      if (k <= 3'd5) begin
         exp_q.push_back({6'(m_ptr), encode(k, r_s, r_t, r_d, s_h, f_n, i_m, t_g)});
         m_count++;
         if (m_ptr == m_top) begin
            m_done = 1; m_full = 1;
         end else begin
            if (l) m_done = 1;
            m_ptr++;
         end
      end else begin
         m_err = 1;
         if (l) m_done = 1;
      end
      @(negedge clk);
      valid_a = 0; valid_b = 0;
   endtask

   task automatic test_reset();
      sel = 0;
      do_reset();
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", o_ready); end
      n_cmp++; if (o_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", o_we); end
      n_cmp++; if (o_addr !== 6'd0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", o_addr); end
      n_cmp++; if (o_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", o_wdata); end
      n_cmp++; if (o_count !== 7'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", o_count); end
      n_cmp++; if ({o_done, o_full, o_err} !== 3'b000) begin
         n_bad++; $display("FAIL rst_flags: done/full/err got %b want 000", {o_done, o_full, o_err});
      end
   endtask

   task automatic test_lw();
      req(3'd1, 5'd16, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0);
      n_cmp++; if (o_we !== 1'b1) begin n_bad++; $display("FAIL lw_we: got %b want 1", o_we); end
      n_cmp++; if (o_addr !== 6'd0) begin n_bad++; $display("FAIL lw_addr: got %0d want 0", o_addr); end
      n_cmp++; if (o_wdata !== 32'h8E080004) begin n_bad++; $display("FAIL lw_wdata: got %h want 8e080004", o_wdata); end
      @(negedge clk);
      n_cmp++; if (o_count !== 7'd1) begin n_bad++; $display("FAIL lw_count: got %0d want 1", o_count); end
      n_cmp++; if (o_we !== 1'b0) begin n_bad++; $display("FAIL lw_we_one_cycle: got %b want 0", o_we); end
   endtask

   task automatic test_rtype();
      req(3'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'hABCD, 26'h3FFFFFF, 1'b0);
      n_cmp++; if (o_wdata !== 32'h01095020) begin n_bad++; $display("FAIL rtype_wdata: got %h want 01095020", o_wdata); end
      n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL rtype_ready_in_write: got %b want 0", o_ready); end
      n_cmp++; if (o_addr !== 6'd1) begin n_bad++; $display("FAIL rtype_addr: got %0d want 1", o_addr); end
      @(negedge clk);
   endtask

   task automatic test_sequence();
      logic [37:0] want[3];
      want[0] = {6'd0, 32'h20080005};
      want[1] = {6'd1, 32'h1022FFFF};
      want[2] = {6'd2, 32'h08000010};
      do_start();
      req(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0);
      req(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
      req(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1);
      @(negedge clk);
      n_cmp++; if (wr_log.size() != 3) begin n_bad++; $display("FAIL seq_nwrites: got %0d want 3", wr_log.size()); end
      for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
         n_cmp++;
         if (wr_log[i] !== want[i]) begin
            n_bad++; $display("FAIL seq_write%0d: got %h want %h", i, wr_log[i], want[i]);
         end
      end
      n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL seq_done: got %b want 1", o_done); end
      n_cmp++; if (o_count !== 7'd3) begin n_bad++; $display("FAIL seq_count: got %0d want 3", o_count); end
      n_cmp++; if (o_full !== 1'b0) begin n_bad++; $display("FAIL seq_full: got %b want 0", o_full); end
      n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL seq_ready_done: got %b want 0", o_ready); end
   endtask

   task automatic test_illegal();
      do_start();
      req(3'd6, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h1234, 26'h55, 1'b0);
      n_cmp++; if (o_we !== 1'b0) begin n_bad++; $display("FAIL ill_we: got %b want 0", o_we); end
      n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %b want 1", o_err); end
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL ill_ready: got %b want 1", o_ready); end
      req(3'd2, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0);
      n_cmp++; if (o_addr !== 6'd0) begin n_bad++; $display("FAIL ill_sw_addr: got %0d want 0", o_addr); end
      n_cmp++; if (o_wdata !== 32'hAC640010) begin n_bad++; $display("FAIL ill_sw_wdata: got %h want ac640010", o_wdata); end
      @(negedge clk);
      n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL ill_err_sticky: got %b want 1", o_err); end
      n_cmp++; if (o_count !== 7'd1) begin n_bad++; $display("FAIL ill_count: got %0d want 1", o_count); end
   endtask

   task automatic test_full();
      sel = 1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req(3'($urandom_range(0, 5)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             6'($urandom), 16'($urandom), 26'($urandom), 1'b0);
      end
      @(negedge clk);
      n_cmp++; if (wr_log.size() != 4) begin n_bad++; $display("FAIL full_nwrites: got %0d want 4", wr_log.size()); end
      for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
         n_cmp++;
         if (wr_log[i] !== exp_q[i]) begin
            n_bad++; $display("FAIL full_write%0d: got %h want %h", i, wr_log[i], exp_q[i]);
         end
      end
      n_cmp++; if ({o_done, o_full} !== 2'b11) begin n_bad++; $display("FAIL full_flags: done/full got %b want 11", {o_done, o_full}); end
      n_cmp++; if (o_count !== 7'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", o_count); end
      kind = 3'd1; last = 0; valid_b = 1;
      repeat (5) @(negedge clk);
      n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL full_stall_ready: got %b want 0", o_ready); end
      n_cmp++; if (wr_log.size() != 4) begin n_bad++; $display("FAIL full_stall_nwrites: got %0d want 4", wr_log.size()); end
      valid_b = 0;
      sel = 0;
   endtask

   task automatic test_reset_and_restart();
      do_reset();
      req(3'd1, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'h7777, 26'd0, 1'b0);
      reset = 1;
      @(negedge clk);
      n_cmp++; if (o_we !== 1'b0) begin n_bad++; $display("FAIL rmw_we: got %b want 0", o_we); end
      n_cmp++; if ({o_ready, o_addr, o_count} !== {1'b1, 6'd0, 7'd0}) begin
         n_bad++; $display("FAIL rmw_state: ready/addr/count got %b/%0d/%0d want 1/0/0", o_ready, o_addr, o_count);
      end
      n_cmp++; if (o_wdata !== 32'h0) begin n_bad++; $display("FAIL rmw_wdata: got %h want 0", o_wdata); end
      reset = 0;
      model_restart();
      req(3'd4, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
      @(negedge clk);
      req(3'd4, 5'd2, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0002, 26'd0, 1'b0);
      @(negedge clk);
      do_start();
      req(3'd2, 5'd7, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0040, 26'd0, 1'b0);
      n_cmp++; if (o_addr !== 6'd0) begin n_bad++; $display("FAIL restart_addr: got %0d want 0", o_addr); end
      @(negedge clk);
      n_cmp++; if (o_count !== 7'd1) begin n_bad++; $display("FAIL restart_count: got %0d want 1", o_count); end
   endtask

   task automatic test_random();
      logic [2:0] k;
      sel = 0;
      do_start();
      for (int i = 0; i < 24; i++) begin
         k = (($urandom % 5) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
         req(k, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
             16'($urandom), 26'($urandom), (i == 23) ? 1'b1 : 1'b0);
      end
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (wr_log.size() != exp_q.size()) begin
         n_bad++; $display("FAIL rnd_nwrites: got %0d want %0d", wr_log.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
         n_cmp++;
         if (wr_log[i] !== exp_q[i]) begin
            n_bad++; $display("FAIL rnd_write%0d: got %h want %h", i, wr_log[i], exp_q[i]);
         end
      end
      n_cmp++; if (o_count !== 7'(m_count)) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", o_count, m_count); end
      n_cmp++; if (o_err !== m_err) begin n_bad++; $display("FAIL rnd_err: got %b want %b", o_err, m_err); end
      n_cmp++; if (o_done !== m_done) begin n_bad++; $display("FAIL rnd_done: got %b want %b", o_done, m_done); end
      n_cmp++; if (o_full !== m_full) begin n_bad++; $display("FAIL rnd_full: got %b want %b", o_full, m_full); end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; sel = 0;
      reset = 1; start = 0; valid_a = 0; valid_b = 0; last = 0;
      kind = 0; rs = 0; rt = 0; rd = 0; shamt = 0; funct = 0; imm = 0; target = 0;
      test_reset();
      test_lw();
      test_rtype();
      test_sequence();
      test_illegal();
      test_full();
      test_reset_and_restart();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
